// File: rtl/queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_pkg
// Description : Shared sizes and types for the queue_fifo block and its
//               optional heartbeat (enabled by QUEUE_FIFO_HEARTBEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package queue_pkg;

    localparam int QUEUE_DATA_W = 4;
    localparam int QUEUE_DEPTH  = 16;
    localparam int QUEUE_ADDR_W = 4;
    localparam int HB_CNT_W     = 28;
    localparam int HB_TAP       = 24;

    typedef logic [QUEUE_DATA_W-1:0] queue_word_t;
    typedef logic [QUEUE_ADDR_W-1:0] queue_ptr_t;

endpackage
`default_nettype wire

// File: rtl/queue_heartbeat.sv
`default_nettype none
// ============================================================================
// Module      : queue_heartbeat
// Description : Free-running counter driving a board heartbeat LED.
//               Used by queue_fifo only when QUEUE_FIFO_HEARTBEAT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_heartbeat
    import queue_pkg::*;
(
    input  logic clk,
    input  logic rst,   // synchronous, active-low
    output logic led
);

    logic [HB_CNT_W-1:0] hb_cnt;

    // Counter clears on reset and otherwise advances every clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + HB_CNT_W'(1);
        end
    end

    assign led = hb_cnt[HB_TAP];

endmodule
`default_nettype wire

// File: rtl/queue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : queue_fifo
// Description : 16 x 4-bit FIFO with registered read data, occupancy count,
//               registered full/empty and sticky overflow/underflow flags.
//               Optional heartbeat LED when QUEUE_FIFO_HEARTBEAT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_fifo
    import queue_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W,
    parameter int DEPTH  = QUEUE_DEPTH,
    parameter int ADDR_W = QUEUE_ADDR_W
)(
    input  logic              clk,
    input  logic              rst,       // synchronous, active-low
    input  logic              wr_en,
    input  logic [DATA_W-1:0] datain,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dataout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef QUEUE_FIFO_HEARTBEAT_EN
    ,
    output logic              led
`endif
);

    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic [ADDR_W:0]   count_next;

    // Accept decisions; a pop frees a slot so a push is allowed while full.
    // A pop on an empty queue is rejected even with a concurrent push.
    always_comb begin
        pop        = rd_en && !empty;
        push       = wr_en && (!full || rd_en);
        count_next = count;
        if (push && !pop) begin
            count_next = count + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (ADDR_W+1)'(1);
        end
    end

    // Storage write; contents survive reset, but reset blocks the write.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= datain;
        end
    end

    // Pointers, count, status flags and registered read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dataout   <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                // Reads the old head; a same-cycle write lands elsewhere.
                dataout <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            if (wr_en && !push) begin
                overflow <= 1'b1;
            end
            if (rd_en && !pop) begin
                underflow <= 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CNT_DEPTH);
            empty <= (count_next == '0);
        end
    end

`ifdef QUEUE_FIFO_HEARTBEAT_EN
    queue_heartbeat u_heartbeat (
        .clk (clk),
        .rst (rst),
        .led (led)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_fifo
// Description : Directed self-checking bench for queue_fifo with a
//               queue-based reference scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] datain = 4'h0;
    logic       rd_en = 1'b0;
    logic [3:0] dataout;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
`ifdef QUEUE_FIFO_HEARTBEAT_EN
    logic       led;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] sb[$];
    logic [3:0] exp_dout = 4'h0;
    logic       exp_ovf  = 1'b0;
    logic       exp_unf  = 1'b0;

    queue_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .datain    (datain),
        .rd_en     (rd_en),
        .dataout   (dataout),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef QUEUE_FIFO_HEARTBEAT_EN
        ,
        .led       (led)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; update the model, then compare all outputs.
    task automatic step(input logic r_n, input logic w, input logic [3:0] d, input logic r, input string tag);
        logic pop_ok;
        logic push_ok;
        rst = r_n; wr_en = w; datain = d; rd_en = r;
        @(posedge clk);
        #1;
        if (!r_n) begin
            sb.delete();
            exp_dout = 4'h0;
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
        end else begin
            pop_ok  = r && (sb.size() > 0);
            push_ok = w && ((sb.size() < 16) || r);
            if (pop_ok)  exp_dout = sb.pop_front();
            if (push_ok) sb.push_back(d);
            if (w && !push_ok) exp_ovf = 1'b1;
            if (r && !pop_ok)  exp_unf = 1'b1;
        end
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        chk({tag, ".dataout"},   32'(dataout),   32'(exp_dout));
        chk({tag, ".count"},     32'(count),     32'(sb.size()));
        chk({tag, ".empty"},     32'(empty),     32'(sb.size() == 0));
        chk({tag, ".full"},      32'(full),      32'(sb.size() == 16));
        chk({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
    endtask

    task automatic push(input logic [3:0] d, input string tag);
        step(1'b1, 1'b1, d, 1'b0, tag);
    endtask

    task automatic pop(input string tag);
        step(1'b1, 1'b0, 4'h0, 1'b1, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b1, 1'b0, 4'h0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        step(1'b0, 1'b0, 4'h0, 1'b0, tag);
    endtask

    initial begin
        // Reset, then idle
        do_reset("rst0");
        do_reset("rst1");
        for (int i = 0; i < 3; i++) idle("idle");
        chk("reset.dataout", 32'(dataout), 32'h0);
        chk("reset.empty",   32'(empty),   32'h1);

        // Short push/pop ordering
        push(4'h1, "p3"); push(4'h2, "p3"); push(4'h3, "p3");
        pop("q3"); chk("q3.first",  32'(dataout), 32'h1);
        pop("q3"); chk("q3.second", 32'(dataout), 32'h2);
        pop("q3"); chk("q3.third",  32'(dataout), 32'h3);
        chk("q3.empty", 32'(empty), 32'h1);

        // Fill to capacity, overflow, drain
        for (int i = 0; i < 16; i++) push(4'(i), "fill");
        chk("fill.full",  32'(full),  32'h1);
        chk("fill.count", 32'(count), 32'd16);
        push(4'h5, "ovf");
        chk("ovf.flag",  32'(overflow), 32'h1);
        chk("ovf.count", 32'(count),    32'd16);
        for (int i = 0; i < 16; i++) begin
            pop("drain");
            chk("drain.order", 32'(dataout), 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'h1);

        // Pointer wrap
        for (int i = 0; i < 12; i++) push(4'(i + 3), "w12");
        for (int i = 0; i < 12; i++) pop("r12");
        for (int i = 0; i < 8; i++) push(4'(4'hA + i), "wrap");
        for (int i = 0; i < 8; i++) begin
            pop("wrapout");
            chk("wrap.order", 32'(dataout), 32'((4'hA + i) & 4'hF));
        end
        chk("wrap.count", 32'(count), 32'd0);

        // Simultaneous push/pop while full
        do_reset("rst2");
        for (int i = 0; i < 16; i++) push(4'(i ^ 3), "fill2");
        step(1'b1, 1'b1, 4'h9, 1'b1, "both_full");
        chk("both_full.head",  32'(dataout),  32'h3);
        chk("both_full.count", 32'(count),    32'd16);
        chk("both_full.ovf",   32'(overflow), 32'h0);
        for (int i = 0; i < 16; i++) pop("drain2");
        chk("drain2.last", 32'(dataout), 32'h9);

        // Simultaneous push/pop while empty
        step(1'b1, 1'b1, 4'h7, 1'b1, "both_empty");
        chk("both_empty.count", 32'(count),     32'd1);
        chk("both_empty.unf",   32'(underflow), 32'h1);
        chk("both_empty.dout",  32'(dataout),   32'h9);
        pop("after_empty");
        chk("after_empty.dout", 32'(dataout), 32'h7);

        // Reset mid-operation, with a concurrent push
        for (int i = 0; i < 5; i++) push(4'(i + 1), "pre_rst");
        step(1'b0, 1'b1, 4'hE, 1'b0, "rst_mid");
        chk("rst_mid.count", 32'(count),     32'd0);
        chk("rst_mid.empty", 32'(empty),     32'h1);
        chk("rst_mid.unf",   32'(underflow), 32'h0);
        pop("post_rst");
        chk("post_rst.unf",  32'(underflow), 32'h1);
        chk("post_rst.dout", 32'(dataout),   32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/queue_fifo.md
Name: queue_fifo

Overview:
- 16-entry, 4-bit first-in/first-out buffer. It is the in-order counterpart to the team's LIFO stack, for producer/consumer paths where arrival order must be kept.
- Independent write and read strobes, registered read data, and occupancy count.
- full/empty status, sticky overflow/underflow error flags.
- Optional board heartbeat LED.

Parameters:
- DATA_W, 4, width of each stored word
- DEPTH, 16, number of entries; must be a power of two
- ADDR_W, 4, pointer width, equal to log2(DEPTH)

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk, 0 = reset
- wr_en  input  1  push request; datain is written when accepted
- datain  input  DATA_W  word to enqueue
- rd_en  input  1  pop request
- dataout  output  DATA_W  registered head word from the last accepted pop
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected
- led  output  1  heartbeat; present only with QUEUE_FIFO_HEARTBEAT_EN

Behaviour:
- Reset (rst == 0 at a clk edge):
  - wr_ptr = rd_ptr = 0, count = 0, dataout = 0.
  - empty = 1, full = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
  - Reset wins over any concurrent wr_en/rd_en.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W bits and wrap naturally: 15 + 1 -> 0.
  - No explicit compare is needed for wrap-around.
- Push accepted when wr_en && (!full || rd_en). Effect: mem[wr_ptr] <= datain; wr_ptr++.
- Pop accepted when rd_en && !empty. Effect: dataout <= mem[rd_ptr]; rd_ptr++.
- Read latency:
  - dataout is valid on the edge that accepts the pop, i.e. visible the cycle after rd_en is asserted.
  - dataout holds its value when no pop is accepted.
- Simultaneous wr_en && rd_en:
  - Not empty (including full): both accepted, count unchanged. The pop returns the old head, never the word being written.
  - Empty: push accepted, pop rejected, count -> 1, underflow set. The pop has no fall-through path.
- count rules: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- full and empty are registered and derived from the next count, so they are coincident with count.
- Rejections:
  - wr_en while full with no rd_en: overflow <= 1; memory, pointers and count unchanged.
  - rd_en while empty: underflow <= 1; dataout unchanged.
  - Both flags are cleared only by reset.
- Capacity: all DEPTH entries are usable; full asserts after 16 pushes with no pops.

Optional Feature:
- Macro: QUEUE_FIFO_HEARTBEAT_EN.
- Defined:
  - A 28-bit free-running counter is instantiated; it clears on reset and increments every clk.
  - led = counter bit 24.
- Undefined:
  - The led port and counter do not exist.
  - FIFO behaviour is identical in both builds.

Decomposition:
- Package queue_pkg:
  - QUEUE_DATA_W = 4, QUEUE_DEPTH = 16, QUEUE_ADDR_W = 4, HB_CNT_W = 28, HB_TAP = 24.
  - typedef queue_word_t, logic [QUEUE_DATA_W-1:0].
  - typedef queue_ptr_t, logic [QUEUE_ADDR_W-1:0].
- Sub-module queue_heartbeat (clk, rst, led), instantiated only under QUEUE_FIFO_HEARTBEAT_EN.
- Storage and pointer logic stay in queue_fifo.

Test Plan:
- Reset, then idle 3 cycles -> dataout=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- Push 0x1,0x2,0x3, then pop 3 times -> dataout sequence 0x1,0x2,0x3, each one cycle after its rd_en; empty=1 after the third pop.
- Push 16 words 0x0..0xF -> full=1, count=16. Extra push 0x5 -> overflow=1, count stays 16. Pop 16 times -> 0x0..0xF in order, confirming the 0x5 push was dropped.
- Wrap check:
  - Push 12 / pop 12, then push 8 words 0xA,0xB,... across the pointer wrap.
  - Pop 8 -> same order returned; count returns to 0.
- Simultaneous push/pop:
  - Full with wr_en=rd_en=1, datain=0x9 -> dataout = old head, count stays 16, overflow stays 0.
  - Empty with both asserted, datain=0x7 -> count=1, underflow=1, dataout unchanged; next pop returns 0x7.
- Reset mid-operation: after 5 pushes assert rst=0 for 1 cycle together with wr_en=1 -> count=0, empty=1, flags=0; a following pop sets underflow=1.
